// File: rtl/rgb_pixel_streamer.sv
// rgb_pixel_streamer: accepts packed RGB pixels on a valid/ready stream and
// replays them as three per-channel pixel/valid outputs in raster order.
// It tracks row/column position, inserts an idle gap after each row and
// tags start-of-frame, end-of-line and end-of-frame on the emitted pixel.
module rgb_pixel_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int LINE_GAP   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    s_valid,
    input  logic [3*DATA_WIDTH-1:0] s_data,
    output logic                    s_ready,
    output logic [DATA_WIDTH-1:0]   pixel_in_r,
    output logic [DATA_WIDTH-1:0]   pixel_in_g,
    output logic [DATA_WIDTH-1:0]   pixel_in_b,
    output logic                    pixel_valid_r,
    output logic                    pixel_valid_g,
    output logic                    pixel_valid_b,
    output logic                    sof,
    output logic                    eol,
    output logic                    frame_done,
    output logic                    busy,
    output logic [15:0]             frame_cnt
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int GAP_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    // With no gap configured the GAP state is never entered, so the reload
    // value only has to be a legal constant.
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((LINE_GAP > 0) ? (LINE_GAP - 1) : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [COL_W-1:0]        col_reg, col_next;
    logic [ROW_W-1:0]        row_reg, row_next;
    logic [GAP_W-1:0]        gap_reg, gap_next;
    logic [15:0]             frame_cnt_reg, frame_cnt_next;
    logic [3*DATA_WIDTH-1:0] pix_reg;
    logic                    valid_reg, valid_next;
    logic                    sof_reg, sof_next;
    logic                    eol_reg, eol_next;
    logic                    done_reg, done_next;
    logic                    load_pix;
    logic                    handshake;

    // Ready depends on state alone so upstream never sees a valid->ready loop.
    assign s_ready   = (state_reg == STREAM);
    assign busy      = (state_reg != IDLE);
    assign handshake = s_valid & s_ready;

    // State register plus position, gap and frame counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            col_reg       <= '0;
            row_reg       <= '0;
            gap_reg       <= '0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            col_reg       <= col_next;
            row_reg       <= row_next;
            gap_reg       <= gap_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    // Next-state, counter update and pixel tag decode.
    always_comb begin
        state_next     = state_reg;
        col_next       = col_reg;
        row_next       = row_reg;
        gap_next       = gap_reg;
        frame_cnt_next = frame_cnt_reg;
        valid_next     = 1'b0;
        sof_next       = 1'b0;
        eol_next       = 1'b0;
        done_next      = 1'b0;
        load_pix       = 1'b0;

        if (abort) begin
            // Abort wins over start and drops any handshake in this cycle.
            state_next = IDLE;
            col_next   = '0;
            row_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next = STREAM;
                        col_next   = '0;
                        row_next   = '0;
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        load_pix   = 1'b1;
                        valid_next = 1'b1;
                        sof_next   = (col_reg == '0) && (row_reg == '0);
                        eol_next   = (col_reg == COL_LAST);
                        if (col_reg < COL_LAST) begin
                            col_next = col_reg + 1'b1;
                        end else if (row_reg < ROW_LAST) begin
                            col_next = '0;
                            row_next = row_reg + 1'b1;
                            if (LINE_GAP != 0) begin
                                state_next = GAP;
                                gap_next   = GAP_INIT;
                            end
                        end else begin
                            // Last pixel of the frame: leave STREAM so that
                            // busy drops while frame_done is on the output.
                            done_next      = 1'b1;
                            state_next     = IDLE;
                            col_next       = '0;
                            row_next       = '0;
                            frame_cnt_next = frame_cnt_reg + 16'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_reg == '0) begin
                        state_next = STREAM;
                    end else begin
                        gap_next = gap_reg - 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output pipeline stage: data holds through bubbles, tags pulse per pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_reg   <= '0;
            valid_reg <= 1'b0;
            sof_reg   <= 1'b0;
            eol_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            if (load_pix) begin
                pix_reg <= s_data;
            end
            valid_reg <= valid_next;
            sof_reg   <= sof_next;
            eol_reg   <= eol_next;
            done_reg  <= done_next;
        end
    end

    assign pixel_in_r    = pix_reg[3*DATA_WIDTH-1:2*DATA_WIDTH];
    assign pixel_in_g    = pix_reg[2*DATA_WIDTH-1:DATA_WIDTH];
    assign pixel_in_b    = pix_reg[DATA_WIDTH-1:0];
    assign pixel_valid_r = valid_reg;
    assign pixel_valid_g = valid_reg;
    assign pixel_valid_b = valid_reg;
    assign sof           = sof_reg;
    assign eol           = eol_reg;
    assign frame_done    = done_reg;
    assign frame_cnt     = frame_cnt_reg;

endmodule

// File: tb/tb_rgb_pixel_streamer.sv
// Directed testbench for rgb_pixel_streamer with a 4x3 image and a 2-cycle
// line gap. Cycle c is the interval after the c-th clock edge of a scenario;
// start in cycle 0 puts the first pixel on the outputs in cycle 2.
module tb_rgb_pixel_streamer;

    localparam int DW = 8;
    localparam logic [23:0] BASE = 24'h010203;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        s_valid;
    logic [23:0] s_data;
    logic        s_ready;
    logic [7:0]  pixel_in_r, pixel_in_g, pixel_in_b;
    logic        pixel_valid_r, pixel_valid_g, pixel_valid_b;
    logic        sof, eol, frame_done, busy;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int n;      // handshakes performed, selects the next upstream pixel
    int p_exp;  // pixels expected so far on the output

    rgb_pixel_streamer #(
        .DATA_WIDTH (DW),
        .IMG_W      (4),
        .IMG_H      (3),
        .LINE_GAP   (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .pixel_in_r    (pixel_in_r),
        .pixel_in_g    (pixel_in_g),
        .pixel_in_b    (pixel_in_b),
        .pixel_valid_r (pixel_valid_r),
        .pixel_valid_g (pixel_valid_g),
        .pixel_valid_b (pixel_valid_b),
        .sof           (sof),
        .eol           (eol),
        .frame_done    (frame_done),
        .busy          (busy),
        .frame_cnt     (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stall-free timeline relative to the start cycle k=0 (4 pixels + 2 gap
    // cycles per row, last pixel at k=17).
    function automatic bit exp_ready(int k);
        return (k >= 1) && (k <= 16) && (((k - 1) % 6) < 4);
    endfunction
    function automatic bit exp_valid(int k);
        return (k >= 2) && (k <= 17) && (((k - 2) % 6) < 4);
    endfunction
    function automatic bit exp_eol(int k);
        return exp_valid(k) && (((k - 2) % 6) == 3);
    endfunction
    function automatic bit exp_busy(int k);
        return (k >= 1) && (k <= 16);
    endfunction

    task automatic do_reset();
        rst     = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        n     = 0;
        p_exp = 0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({pixel_valid_r, pixel_valid_g, pixel_valid_b, sof, eol, frame_done, busy, s_ready} !== 8'h00 ||
                frame_cnt !== 16'd0 || {pixel_in_r, pixel_in_g, pixel_in_b} !== 24'h0) begin
                errors++;
                $display("FAIL reset c=%0d ctrl=%b%b%b%b%b%b%b%b cnt=%h data=%h want all 0", c,
                         pixel_valid_r, pixel_valid_g, pixel_valid_b, sof, eol, frame_done, busy, s_ready,
                         frame_cnt, {pixel_in_r, pixel_in_g, pixel_in_b});
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        logic [4:0]  got, want;
        logic [23:0] ep;
        int k;
        do_reset();
        s_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            start  = (c == 0);
            s_data = BASE + 24'(n);
            @(negedge clk);
            if (s_valid && s_ready && !abort) n++;
            k = c;
            want = {exp_valid(k), k == 2, exp_eol(k), k == 17, exp_busy(k)};
            got  = {pixel_valid_r, sof, eol, frame_done, busy};
            checks++;
            if (got !== want || {pixel_valid_g, pixel_valid_b} !== {2{want[4]}} || s_ready !== exp_ready(k)) begin
                errors++;
                $display("FAIL single ctrl c=%0d got v/sof/eol/fd/busy=%b vg=%b vb=%b rdy=%b want %b rdy=%b",
                         c, got, pixel_valid_g, pixel_valid_b, s_ready, want, exp_ready(k));
            end
            if (exp_valid(k)) begin
                ep = BASE + 24'(p_exp);
                p_exp++;
                checks++;
                if ({pixel_in_r, pixel_in_g, pixel_in_b} !== ep) begin
                    errors++;
                    $display("FAIL single data c=%0d got %h want %h", c, {pixel_in_r, pixel_in_g, pixel_in_b}, ep);
                end
            end
            checks++;
            if (frame_cnt !== ((c >= 17) ? 16'd1 : 16'd0)) begin
                errors++;
                $display("FAIL single frame_cnt c=%0d got %0d want %0d", c, frame_cnt, (c >= 17) ? 1 : 0);
            end
        end
        start = 1'b0;
        $display("test_single_frame done: %0d pixels expected", p_exp);
    endtask

    task automatic test_bubbles();
        // Upstream drops valid in cycles 2..4, right after the first pixel.
        localparam logic [31:0] V_MASK = 32'h001E79C4;
        localparam logic [31:0] E_MASK = 32'h00104100;
        localparam logic [31:0] R_MASK = 32'h000F3CFE;
        localparam logic [31:0] B_MASK = 32'h000FFFFE;
        logic [4:0]  got, want;
        logic [23:0] ep;
        int seen;
        do_reset();
        seen = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            start   = (c == 0);
            s_valid = !((c >= 2) && (c <= 4));
            s_data  = BASE + 24'(n);
            @(negedge clk);
            if (s_valid && s_ready && !abort) n++;
            want = {V_MASK[c], c == 2, E_MASK[c], c == 20, B_MASK[c]};
            got  = {pixel_valid_r, sof, eol, frame_done, busy};
            checks++;
            if (got !== want || {pixel_valid_g, pixel_valid_b} !== {2{want[4]}} || s_ready !== R_MASK[c]) begin
                errors++;
                $display("FAIL bubble ctrl c=%0d got v/sof/eol/fd/busy=%b rdy=%b want %b rdy=%b",
                         c, got, s_ready, want, R_MASK[c]);
            end
            if (pixel_valid_r) seen++;
            if (V_MASK[c]) begin
                ep = BASE + 24'(p_exp);
                p_exp++;
                checks++;
                if ({pixel_in_r, pixel_in_g, pixel_in_b} !== ep) begin
                    errors++;
                    $display("FAIL bubble data c=%0d got %h want %h", c, {pixel_in_r, pixel_in_g, pixel_in_b}, ep);
                end
            end
        end
        s_valid = 1'b1;
        checks++;
        if (seen != 12 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL bubble totals pixels=%0d frame_cnt=%0d want 12 and 1", seen, frame_cnt);
        end
        $display("test_bubbles done: %0d pixels seen", seen);
    endtask

    task automatic test_back_to_back();
        logic [4:0]  got, want;
        logic [23:0] ep;
        logic [15:0] efc;
        int k;
        do_reset();
        s_valid = 1'b1;
        for (int c = 0; c < 37; c++) begin
            @(posedge clk); #1;
            start  = (c == 0) || (c == 17);
            s_data = BASE + 24'(n);
            @(negedge clk);
            if (s_valid && s_ready && !abort) n++;
            k = (c >= 18) ? (c - 17) : c;
            efc = (c >= 34) ? 16'd2 : ((c >= 17) ? 16'd1 : 16'd0);
            want = {exp_valid(k), k == 2, exp_eol(k), k == 17, exp_busy(k)};
            got  = {pixel_valid_r, sof, eol, frame_done, busy};
            checks++;
            if (got !== want || {pixel_valid_g, pixel_valid_b} !== {2{want[4]}} || s_ready !== exp_ready(k)) begin
                errors++;
                $display("FAIL b2b ctrl c=%0d got v/sof/eol/fd/busy=%b rdy=%b want %b rdy=%b",
                         c, got, s_ready, want, exp_ready(k));
            end
            if (exp_valid(k)) begin
                ep = BASE + 24'(p_exp);
                p_exp++;
                checks++;
                if ({pixel_in_r, pixel_in_g, pixel_in_b} !== ep) begin
                    errors++;
                    $display("FAIL b2b data c=%0d got %h want %h", c, {pixel_in_r, pixel_in_g, pixel_in_b}, ep);
                end
            end
            checks++;
            if (frame_cnt !== efc) begin
                errors++;
                $display("FAIL b2b frame_cnt c=%0d got %0d want %0d", c, frame_cnt, efc);
            end
        end
        start = 1'b0;
        $display("test_back_to_back done: frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_abort();
        // Abort in cycle 9, the handshake slot of row 1 col 2; restart in 12.
        logic [4:0]  got, want;
        logic [23:0] ep;
        logic [15:0] efc;
        bit er, ev;
        int k;
        do_reset();
        s_valid = 1'b1;
        for (int c = 0; c < 32; c++) begin
            @(posedge clk); #1;
            start  = (c == 0) || (c == 12);
            abort  = (c == 9);
            s_data = BASE + 24'(n);
            @(negedge clk);
            if (s_valid && s_ready && !abort) n++;
            k = (c >= 12) ? (c - 12) : c;
            efc = ((c >= 12) && (k >= 17)) ? 16'd1 : 16'd0;
            if (c == 10 || c == 11) begin
                want = 5'b00000;
                er   = 1'b0;
                ev   = 1'b0;
            end else begin
                want = {exp_valid(k), k == 2, exp_eol(k), k == 17, exp_busy(k)};
                er   = exp_ready(k);
                ev   = exp_valid(k);
            end
            got = {pixel_valid_r, sof, eol, frame_done, busy};
            checks++;
            if (got !== want || {pixel_valid_g, pixel_valid_b} !== {2{want[4]}} || s_ready !== er) begin
                errors++;
                $display("FAIL abort ctrl c=%0d got v/sof/eol/fd/busy=%b rdy=%b want %b rdy=%b",
                         c, got, s_ready, want, er);
            end
            if (ev) begin
                ep = BASE + 24'(p_exp);
                p_exp++;
                checks++;
                if ({pixel_in_r, pixel_in_g, pixel_in_b} !== ep) begin
                    errors++;
                    $display("FAIL abort data c=%0d got %h want %h", c, {pixel_in_r, pixel_in_g, pixel_in_b}, ep);
                end
            end
            checks++;
            if (frame_cnt !== efc) begin
                errors++;
                $display("FAIL abort frame_cnt c=%0d got %0d want %0d", c, frame_cnt, efc);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        $display("test_abort done: frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_start_while_busy();
        logic [4:0]  got, want;
        logic [23:0] ep;
        int k;
        do_reset();
        s_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            start  = (c == 0) || (c == 6) || (c == 10);
            s_data = BASE + 24'(n);
            @(negedge clk);
            if (s_valid && s_ready && !abort) n++;
            k = c;
            want = {exp_valid(k), k == 2, exp_eol(k), k == 17, exp_busy(k)};
            got  = {pixel_valid_r, sof, eol, frame_done, busy};
            checks++;
            if (got !== want || s_ready !== exp_ready(k)) begin
                errors++;
                $display("FAIL busy_start ctrl c=%0d got v/sof/eol/fd/busy=%b rdy=%b want %b rdy=%b",
                         c, got, s_ready, want, exp_ready(k));
            end
            if (exp_valid(k)) begin
                ep = BASE + 24'(p_exp);
                p_exp++;
                checks++;
                if ({pixel_in_r, pixel_in_g, pixel_in_b} !== ep) begin
                    errors++;
                    $display("FAIL busy_start data c=%0d got %h want %h", c, {pixel_in_r, pixel_in_g, pixel_in_b}, ep);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL busy_start frame_cnt got %0d want 1", frame_cnt);
        end
        $display("test_start_while_busy done");
    endtask

    task automatic test_async_reset();
        do_reset();
        s_valid = 1'b1;
        // One full frame, then stop mid-way through a second one (k=9).
        for (int c = 0; c < 28; c++) begin
            @(posedge clk); #1;
            start  = (c == 0) || (c == 18);
            s_data = BASE + 24'(n);
            @(negedge clk);
            if (s_valid && s_ready && !abort) n++;
        end
        start = 1'b0;
        checks++;
        if (pixel_valid_r !== 1'b1 || busy !== 1'b1 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL async pre valid=%b busy=%b cnt=%0d want 1 1 1", pixel_valid_r, busy, frame_cnt);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({pixel_valid_r, pixel_valid_g, pixel_valid_b, sof, eol, frame_done, busy, s_ready} !== 8'h00 ||
            frame_cnt !== 16'd0 || {pixel_in_r, pixel_in_g, pixel_in_b} !== 24'h0) begin
            errors++;
            $display("FAIL async clear ctrl=%b%b%b%b%b%b%b%b cnt=%0d data=%h want all 0",
                     pixel_valid_r, pixel_valid_g, pixel_valid_b, sof, eol, frame_done, busy, s_ready,
                     frame_cnt, {pixel_in_r, pixel_in_g, pixel_in_b});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({pixel_valid_r, busy, s_ready} !== 3'b000 || frame_cnt !== 16'd0) begin
                errors++;
                $display("FAIL async idle c=%0d valid/busy/rdy=%b%b%b cnt=%0d want 000 0",
                         c, pixel_valid_r, busy, s_ready, frame_cnt);
            end
        end
        $display("test_async_reset done");
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        test_reset();
        test_single_frame();
        test_bubbles();
        test_back_to_back();
        test_abort();
        test_start_while_busy();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_pixel_streamer.md
# rgb_pixel_streamer

Frame-level source that feeds the RGB convolution layer. It accepts packed 24-bit RGB pixels from an upstream valid/ready stream and drives the layer's three per-channel pixel/valid inputs in raster order. It tracks row and column position, inserts a programmable idle gap after each row, and flags the first pixel of each frame, the end of each line and the end of each frame.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per colour channel
- IMG_W, 32, pixels per row (≥2)
- IMG_H, 32, rows per frame (≥2)
- LINE_GAP, 2, idle cycles inserted after each row except the last (0 allowed)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to stream one frame; honoured only in IDLE
- abort  in  1  synchronous; return to IDLE immediately
- s_valid  in  1  upstream pixel valid
- s_data  in  3*DATA_WIDTH  upstream pixel, {R[23:16], G[15:8], B[7:0]} for DATA_WIDTH=8
- s_ready  out  1  upstream ready
- pixel_in_r / pixel_in_g / pixel_in_b  out  DATA_WIDTH each  channel data to the conv layer
- pixel_valid_r / pixel_valid_g / pixel_valid_b  out  1 each  channel valids; always equal
- sof  out  1  high with the first pixel of a frame
- eol  out  1  high with the last pixel of each row
- frame_done  out  1  high with the last pixel of the frame
- busy  out  1  state ≠ IDLE
- frame_cnt  out  16  number of completed frames; wraps at 0xFFFF→0

## Operation
- States: IDLE, STREAM, GAP.
- IDLE: s_ready=0. When start=1, go to STREAM with col=0 and row=0.
- STREAM: s_ready=1. A handshake is s_valid & s_ready.
  - On each handshake, register the three channel bytes and set all valids to 1 on the next cycle.
  - No handshake in a cycle gives valids=0 next cycle. This is a bubble; the data registers hold their last value.
- Column/row update on a handshake:
  - col < IMG_W-1: col+1.
  - col = IMG_W-1 and row < IMG_H-1: col=0, row+1. Go to GAP with gap_cnt=LINE_GAP-1, or stay in STREAM if LINE_GAP=0.
  - col = IMG_W-1 and row = IMG_H-1: go to IDLE and increment frame_cnt.
- GAP: s_ready=0. Decrement gap_cnt; go to STREAM when gap_cnt=0.
- sof, eol and frame_done are registered alongside the pixel they tag and are high for exactly one cycle.
- Because frame_done implies eol, the last pixel carries eol=1 and frame_done=1.
- start is ignored when state ≠ IDLE.
- abort overrides everything and has priority over start in the same cycle:
  - next state IDLE, col=row=0;
  - valids, sof, eol and frame_done go to 0 next cycle;
  - frame_cnt is unchanged;
  - a handshake in the abort cycle is dropped.
- Reset values: all outputs 0, state IDLE, counters 0.

## Timing
- s_ready is combinational from state only. It never depends on s_valid.
- Latency from handshake to pixel_valid_* is 1 cycle. Throughput is 1 pixel/clk within a row.
- start at cycle 0 gives s_ready=1 at cycle 1. With s_valid held high, the first pixel (sof=1) appears at cycle 2.
- Row period with no bubbles: IMG_W+LINE_GAP cycles.
- Last pixel appears at cycle 1 + IMG_W·IMG_H + (IMG_H-1)·LINE_GAP.
- busy falls in the same cycle that frame_done is high. A start in that cycle is accepted, allowing back-to-back frames with 1 idle cycle.
- Upstream stalls (s_valid=0) pause col/row counting and produce valid bubbles. Gap length is counted in cycles and is unaffected by stalls.
- Asserting rst mid-frame clears all outputs asynchronously. After release the block sits in IDLE and waits for start.

## Test plan
Bench parameters: IMG_W=4, IMG_H=3, LINE_GAP=2.
- Reset and single frame:
  - Stimulus: release rst; start at cycle 0; s_valid=1 with an incrementing pattern 0x010203 + n.
  - Required: 12 valid pixels at cycles 2–5, 8–11 and 14–17.
  - Required: sof at cycle 2; eol at cycles 5, 11 and 17; frame_done at cycle 17; frame_cnt=1; R/G/B bytes match the pattern.
- Upstream bubbles: drop s_valid for 3 cycles mid-row.
  - Required: the valid gap is exactly 3 cycles; col resumes; pixel order is intact; total pixel count is 12.
- Back-to-back frames: pulse start in the frame_done cycle.
  - Required: the second sof arrives 2 cycles later; frame_cnt=2 after the second frame.
- Abort at row 1, col 2, with s_valid=1.
  - Required: next cycle all valids=0, busy=0, no frame_done, frame_cnt unchanged.
  - Required: a new start then produces a full frame beginning at row 0.
- Start while busy: pulse start mid-frame.
  - Required: no effect on counters or output sequence.
- Async reset mid-frame: assert rst between clock edges.
  - Required: valids, busy and frame_cnt are 0 immediately and s_ready=0.
